// File: rtl/div_pkg.sv
// Shared widths and the single restoring-division step used by every pipeline stage.
package div_pkg;

    // Widest divisor the step function handles (M + 1 must not exceed STEP_W).
    localparam int STEP_W = 32;

    typedef struct packed {
        logic              qbit;
        logic [STEP_W:0]   rem;
    } step_t;

    function automatic int calc_qw(input int n, input int frac);
        return n + frac;
    endfunction

    function automatic int calc_lat(input int n, input int frac);
        return n + frac;
    endfunction

    // Shift one dividend bit into the partial remainder, then compare and restore.
    function automatic step_t div_step(
        input logic [STEP_W-1:0] rem,
        input logic              din,
        input logic [STEP_W-1:0] dvs
    );
        logic [STEP_W:0] sh;
        logic [STEP_W:0] dv_ext;
        step_t           res;
        sh     = {rem, din};
        dv_ext = {1'b0, dvs};
        if (sh >= dv_ext) begin
            res.qbit = 1'b1;
            res.rem  = sh - dv_ext;
        end else begin
            res.qbit = 1'b0;
            res.rem  = sh;
        end
        return res;
    endfunction

endpackage

// File: rtl/divider_frac_stage.sv
// One registered restoring-division step: consumes dividend bit IDX and produces quotient bit IDX.
module divider_frac_stage
    import div_pkg::*;
#(
    parameter int M     = 11,
    parameter int TAG_W = 4,
    parameter int QW    = 27,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_adv,
    input  logic             i_vld,
    input  logic [M-1:0]     i_rem,
    input  logic [QW-1:0]    i_d,
    input  logic [QW-1:0]    i_q,
    input  logic [M-1:0]     i_dvs,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_zero,
    output logic             o_vld,
    output logic [M-1:0]     o_rem,
    output logic [QW-1:0]    o_d,
    output logic [QW-1:0]    o_q,
    output logic [M-1:0]     o_dvs,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_zero
);

    step_t            w_step;
    logic             w_unused;

    logic             r_vld;
    logic [M-1:0]     r_rem;
    logic [QW-1:0]    r_d;
    logic [QW-1:0]    r_q;
    logic [M-1:0]     r_dvs;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;

    assign w_step = div_step(STEP_W'(i_rem), i_d[IDX], STEP_W'(i_dvs));

    // Remainder stays below the divisor, so the upper step bits are always zero for valid beats.
    assign w_unused = ^{w_step.rem[STEP_W:M], i_q[IDX]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= 1'b0;
        end else if (i_adv) begin
            r_vld <= i_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_rem     <= w_step.rem[M-1:0];
            r_d       <= i_d;
            r_q       <= i_q;
            r_q[IDX]  <= w_step.qbit;
            r_dvs     <= i_dvs;
            r_tag     <= i_tag;
            r_zero    <= i_zero;
        end
    end

    assign o_vld  = r_vld;
    assign o_rem  = r_rem;
    assign o_d    = r_d;
    assign o_q    = r_q;
    assign o_dvs  = r_dvs;
    assign o_tag  = r_tag;
    assign o_zero = r_zero;

endmodule

// File: rtl/divider_frac_pipe.sv
// Fully pipelined unsigned restoring divider with fractional quotient, valid/ready flow control and tag sideband.
module divider_frac_pipe
    import div_pkg::*;
#(
    parameter  int N     = 19,
    parameter  int M     = 11,
    parameter  int FRAC  = 8,
    parameter  int TAG_W = 4,
    localparam int QW    = calc_qw(N, FRAC),
    localparam int LAT   = calc_lat(N, FRAC)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     dividend,
    input  logic [M-1:0]     divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    quotient,
    output logic [M-1:0]     remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_zero,
    output logic             busy
);

    logic             w_adv;
    logic             w_unused;

    logic [LAT:0]     w_vld;
    logic [M-1:0]     w_rem  [LAT+1];
    logic [QW-1:0]    w_d    [LAT+1];
    logic [QW-1:0]    w_q    [LAT+1];
    logic [M-1:0]     w_dvs  [LAT+1];
    logic [TAG_W-1:0] w_tag  [LAT+1];
    logic             w_zero [LAT+1];

    logic             r_vld_p0;
    logic [QW-1:0]    r_d_p0;
    logic [M-1:0]     r_dvs_p0;
    logic [TAG_W-1:0] r_tag_p0;
    logic             r_zero_p0;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---- stage 0: input register ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld_p0 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_d_p0    <= QW'(dividend) << FRAC;
            r_dvs_p0  <= divisor;
            r_tag_p0  <= in_tag;
            r_zero_p0 <= (divisor == '0);
        end
    end

    assign w_vld[0]  = r_vld_p0;
    assign w_rem[0]  = '0;
    assign w_d[0]    = r_d_p0;
    assign w_q[0]    = '0;
    assign w_dvs[0]  = r_dvs_p0;
    assign w_tag[0]  = r_tag_p0;
    assign w_zero[0] = r_zero_p0;

    // ---- stages 1..LAT: one quotient bit each, MSB first ----
    for (genvar gi = 1; gi <= LAT; gi++) begin : g_stage
        divider_frac_stage #(
            .M     (M),
            .TAG_W (TAG_W),
            .QW    (QW),
            .IDX   (QW - gi)
        ) u_stage (
            .clk    (clk),
            .rstn   (rstn),
            .i_adv  (w_adv),
            .i_vld  (w_vld[gi-1]),
            .i_rem  (w_rem[gi-1]),
            .i_d    (w_d[gi-1]),
            .i_q    (w_q[gi-1]),
            .i_dvs  (w_dvs[gi-1]),
            .i_tag  (w_tag[gi-1]),
            .i_zero (w_zero[gi-1]),
            .o_vld  (w_vld[gi]),
            .o_rem  (w_rem[gi]),
            .o_d    (w_d[gi]),
            .o_q    (w_q[gi]),
            .o_dvs  (w_dvs[gi]),
            .o_tag  (w_tag[gi]),
            .o_zero (w_zero[gi])
        );
    end

    assign w_unused = ^{w_d[LAT], w_dvs[LAT]};

    // ---- output mapping: last-stage registers gated by their valid bit ----
    assign out_valid = w_vld[LAT];
    assign quotient  = !out_valid ? '0 : (w_zero[LAT] ? '1 : w_q[LAT]);
    assign remainder = (out_valid && !w_zero[LAT]) ? w_rem[LAT] : '0;
    assign out_tag   = out_valid ? w_tag[LAT] : '0;
    assign div_zero  = out_valid && w_zero[LAT];
    assign busy      = |w_vld;

endmodule

// File: doc/divider_frac_pipe.md
Name: divider_frac_pipe

Overview:
- Parametrised, fully pipelined unsigned restoring divider. Produces a fixed-point quotient with FRAC fractional bits and a final remainder.
- Successor to the fixed-ratio divider used for score normalisation (19-bit dividend, 11-bit divisor, 8 fractional bits).
- Adds a valid/ready handshake with backpressure, a sideband tag, divide-by-zero detection and a busy indicator.
- Sits between the shift/accumulate stage and the score-line logic.

Parameters:
- N, 19, dividend width (bits).
- M, 11, divisor width (bits); M <= N.
- FRAC, 8, fractional quotient bits; 0 allowed.
- TAG_W, 4, sideband tag width; >= 1.
- Derived: QW = N+FRAC (quotient width), LAT = N+FRAC (pipeline stages).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts input this cycle.
- dividend  in  N  unsigned dividend.
- divisor  in  M  unsigned divisor.
- in_tag  in  TAG_W  opaque sideband, returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  QW  floor(dividend*2^FRAC / divisor); low FRAC bits are the fraction.
- remainder  out  M  dividend*2^FRAC - quotient*divisor; always < divisor.
- out_tag  out  TAG_W  in_tag of this result.
- div_zero  out  1  this result had divisor == 0.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0. out_valid, quotient, remainder, out_tag, div_zero and busy = 0. in_ready = 1 once rstn is high.
- Reset mid-operation: every in-flight beat is discarded. Nothing is emitted after release.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Every pipeline register updates only when adv = 1.
- Transfers: input accepted on a rising edge with in_valid && in_ready; output consumed on a rising edge with out_valid && out_ready.
- Stage 0 (input register): captures the extended dividend D = {dividend, FRAC'b0}, divisor, tag and a zero flag (divisor == 0). Partial remainder is cleared, valid = in_valid.
- Stage i (1..LAT), one quotient bit per stage, MSB first:
  - Shift: r' = {r, next bit of D} (M+1 bits).
  - If r' >= divisor, then r = r' - divisor and q bit = 1; otherwise r = r' and q bit = 0.
  - Divisor, tag, zero flag and valid pipe alongside.
- Latency: a beat accepted at edge t shows out_valid = 1 after edge t+LAT, provided no stall occurs. Each cycle with adv = 0 adds exactly one cycle.
- Throughput: one result per cycle while out_ready = 1. No bubbles are inserted.
- Stall: when out_valid && !out_ready, all stages and outputs hold their values. in_ready = 0. No beat is lost or duplicated.
- Simultaneous input accept and output consume in one cycle: both happen and the pipeline shifts by one.
- Bubbles (invalid stages) still shift. Valid bits gate the outputs only.
- Divide by zero: quotient = all ones (2^QW - 1), remainder = 0, div_zero = 1. Latency is unchanged.
- Width rule: quotient cannot overflow QW when divisor >= 1. The partial-remainder datapath is M+1 bits wide and the comparator is unsigned.
- Output ordering is strictly FIFO; tags are never reordered.
- Outputs are registered (last stage); no combinational path from inputs to outputs. in_ready depends combinationally on out_ready and out_valid only.

Decomposition:
- Package div_pkg holds the step function (shift/compare/subtract on M+1 bits) and the derived-width constants QW and LAT as functions of N, M and FRAC.
- One sub-module, divider_frac_stage: a single registered step. Parameters are M, TAG_W and the index of the D bit it consumes. Ports cover the valid/r/q/divisor/tag/zero in/out signals plus adv.
- The top instantiates LAT of these via generate, plus the input register and output mapping.

Test Plan (N=19, M=11, FRAC=8, QW=27, LAT=27, out_ready=1 unless stated):
- 264/8 -> quotient 8448 (33.0), remainder 0, div_zero 0, out_valid exactly 27 cycles after accept.
- Back-to-back beats 264/8, 64/8, 4514/66 with tags 1, 2, 3 -> consecutive results: 8448 r0 tag1; 2048 r0 tag2; 17508 r56 tag3.
- 100/0 -> quotient 134217727, remainder 0, div_zero 1, latency 27.
- Fill the pipeline with 30 beats, then hold out_ready = 0 for 10 cycles -> in_ready = 0 and outputs frozen throughout. After release the remaining results stream out in order with no loss or duplicates. Check every beat against the reference model q*d + r == dividend*256, r < d.
- Assert rstn low for one cycle with 10 beats in flight -> out_valid, busy and outputs go to 0 immediately, and no result appears within 40 cycles after release.
- Random 2000 beats with random in_valid/out_ready -> all results match the model, in order, tags intact. Boundary operands: dividend 0, dividend 524287 / divisor 1 (quotient 134217472), divisor 2047.
